// File: rtl/ttl_addr_latch_scan_if.sv
// ---------------------------------------------------------------------------
// ttl_addr_latch_scan_if
//   Bus bundle for the addressable latch / scanning decoder.
//   Handshake: there is no valid/ready pair. The write controls (g_n, clr_n,
//   addr, d) are sampled on every rising clock edge. The outputs are either
//   registered or decoded from registers plus scan_en.
//   Signals:
//     addr      master->slave  latch address
//     d         master->slave  data bit for q[addr]
//     g_n       master->slave  active-low write enable
//     clr_n     master->slave  active-low clear / demux select
//     scan_en   master->slave  scan counter run enable
//     q         slave->master  latch bank contents
//     scan_addr slave->master  current scan position
//     scan_wrap slave->master  one-cycle pulse after scan_addr wraps to 0
//     y         slave->master  scan strobe (one-hot or one-cold)
//     q_sel     slave->master  q[scan_addr]
// ---------------------------------------------------------------------------
interface ttl_addr_latch_scan_if #(
   parameter int ADDR_W = 3
);
   localparam int N = 2 ** ADDR_W;

   logic [ADDR_W-1:0] addr;
   logic              d;
   logic              g_n;
   logic              clr_n;
   logic              scan_en;
   logic [N-1:0]      q;
   logic [ADDR_W-1:0] scan_addr;
   logic              scan_wrap;
   logic [N-1:0]      y;
   logic              q_sel;

   modport master (
      output addr, d, g_n, clr_n, scan_en,
      input  q, scan_addr, scan_wrap, y, q_sel
   );

   modport slave (
      input  addr, d, g_n, clr_n, scan_en,
      output q, scan_addr, scan_wrap, y, q_sel
   );
endinterface

// File: rtl/ttl_addr_latch_scan.sv
// ---------------------------------------------------------------------------
// ttl_addr_latch_scan
//   Clocked 74259-style addressable latch bank (2**ADDR_W bits) combined with
//   a 74138-style scanning decoder driven by a free-running scan counter.
//   Ports:
//     clk    in  rising-edge clock
//     reset  in  asynchronous active-high reset
//     bus    slave modport of ttl_addr_latch_scan_if (write controls in;
//            q, scan_addr, scan_wrap, y, q_sel out)
//   Parameters:
//     ADDR_W   address width, N = 2**ADDR_W latches
//     SCAN_DIV clocks per scan step (1 = advance every clock)
//     INVERT   1 = y active-low, 0 = y active-high
// ---------------------------------------------------------------------------
module ttl_addr_latch_scan #(
   parameter int ADDR_W   = 3,
   parameter int SCAN_DIV = 4,
   parameter int INVERT   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   ttl_addr_latch_scan_if.slave bus
);
   localparam int N     = 2 ** ADDR_W;
   // A one-bit divider is kept even for SCAN_DIV=1; it then simply stays 0.
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N - 1);
   localparam logic [N-1:0]      ONE_N = {{(N-1){1'b0}}, 1'b1};

   logic [N-1:0]      r_q;
   logic [N-1:0]      w_q_next;
   logic [ADDR_W-1:0] r_scan_addr;
   logic [DIV_W-1:0]  r_div;
   logic              r_scan_wrap;
   logic [N-1:0]      w_strobe;
   logic [N-1:0]      w_y_act;

   // Latch bank next value, selected by the {g_n, clr_n} mode pair.
   always_comb begin
      w_q_next = r_q;
      case ({bus.g_n, bus.clr_n})
         2'b01: w_q_next[bus.addr] = bus.d;        // addressable latch
         2'b00: begin                              // demux
            w_q_next            = '0;
            w_q_next[bus.addr]  = bus.d;
         end
         2'b10: w_q_next = '0;                     // clear
         default: w_q_next = r_q;                  // memory
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q <= '0;
      end else begin
         r_q <= w_q_next;
      end
   end

   // Scanner: divider and scan position. Disabling clears the divider so a
   // re-enable always waits a full SCAN_DIV clocks before the next step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div       <= '0;
         r_scan_addr <= '0;
         r_scan_wrap <= 1'b0;
      end else if (!bus.scan_en) begin
         r_div       <= '0;
         r_scan_wrap <= 1'b0;
      end else if (r_div == DIV_LAST) begin
         r_div       <= '0;
         r_scan_addr <= r_scan_addr + ADDR_W'(1);
         r_scan_wrap <= (r_scan_addr == ADDR_LAST);
      end else begin
         r_div       <= r_div + DIV_W'(1);
         r_scan_wrap <= 1'b0;
      end
   end

   assign w_strobe = ONE_N << r_scan_addr;
   assign w_y_act  = bus.scan_en ? w_strobe : '0;

   assign bus.q         = r_q;
   assign bus.scan_addr = r_scan_addr;
   assign bus.scan_wrap = r_scan_wrap;
   assign bus.y         = (INVERT != 0) ? ~w_y_act : w_y_act;
   assign bus.q_sel     = r_q[r_scan_addr];
endmodule

// File: tb/tb_ttl_addr_latch_scan.sv
// ---------------------------------------------------------------------------
// tb_ttl_addr_latch_scan
//   Two instances share one stimulus stream: dut0 (SCAN_DIV=4, INVERT=0) and
//   dut1 (SCAN_DIV=1, INVERT=1). Expected values come from a reference model
//   that tracks scan position as base + enabled_clocks / SCAN_DIV (mod 8).
// ---------------------------------------------------------------------------
module tb_ttl_addr_latch_scan;
   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ttl_addr_latch_scan_if #(.ADDR_W(3)) bus0 ();
   ttl_addr_latch_scan_if #(.ADDR_W(3)) bus1 ();

   assign bus1.addr    = bus0.addr;
   assign bus1.d       = bus0.d;
   assign bus1.g_n     = bus0.g_n;
   assign bus1.clr_n   = bus0.clr_n;
   assign bus1.scan_en = bus0.scan_en;

   ttl_addr_latch_scan #(.ADDR_W(3), .SCAN_DIV(4), .INVERT(0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0.slave)
   );

   ttl_addr_latch_scan #(.ADDR_W(3), .SCAN_DIV(1), .INVERT(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.slave)
   );

   // ---------------- reference model ----------------
   int         n_checks = 0;
   int         n_err    = 0;
   logic [7:0] m_q;
   int         m_base0, m_run0, m_base1, m_run1;
   logic       m_wrap0, m_wrap1;

   function automatic int pos(input int base, input int run, input int div);
      return (base + run / div) % 8;
   endfunction

   task automatic model_reset();
      m_q     = 8'h00;
      m_base0 = 0; m_run0 = 0; m_wrap0 = 1'b0;
      m_base1 = 0; m_run1 = 0; m_wrap1 = 1'b0;
   endtask

   task automatic model_edge();
      logic [7:0] nq;
      nq = m_q;
      if (!bus0.g_n && bus0.clr_n) begin
         nq[bus0.addr] = bus0.d;
      end else if (!bus0.g_n && !bus0.clr_n) begin
         nq = 8'h00;
         nq[bus0.addr] = bus0.d;
      end else if (bus0.g_n && !bus0.clr_n) begin
         nq = 8'h00;
      end
      m_q = nq;
      if (bus0.scan_en) begin
         m_run0++;
         m_run1++;
         m_wrap0 = (m_run0 % 4 == 0) && (pos(m_base0, m_run0, 4) == 0);
         m_wrap1 = (pos(m_base1, m_run1, 1) == 0);
      end else begin
         m_base0 = pos(m_base0, m_run0, 4); m_run0 = 0; m_wrap0 = 1'b0;
         m_base1 = pos(m_base1, m_run1, 1); m_run1 = 0; m_wrap1 = 1'b0;
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ph);
      int         a0, a1;
      logic [7:0] e_y0, e_y1;
      a0   = pos(m_base0, m_run0, 4);
      a1   = pos(m_base1, m_run1, 1);
      e_y0 = bus0.scan_en ? (8'd1 << a0) : 8'h00;
      e_y1 = bus0.scan_en ? ~(8'd1 << a1) : 8'hFF;
      chk({ph, ".q"},          32'(bus0.q),         32'(m_q));
      chk({ph, ".scan_addr0"}, 32'(bus0.scan_addr), 32'(a0));
      chk({ph, ".scan_wrap0"}, 32'(bus0.scan_wrap), 32'(m_wrap0));
      chk({ph, ".y0"},         32'(bus0.y),         32'(e_y0));
      chk({ph, ".q_sel0"},     32'(bus0.q_sel),     32'(m_q[a0]));
      chk({ph, ".q1"},         32'(bus1.q),         32'(m_q));
      chk({ph, ".scan_addr1"}, 32'(bus1.scan_addr), 32'(a1));
      chk({ph, ".scan_wrap1"}, 32'(bus1.scan_wrap), 32'(m_wrap1));
      chk({ph, ".y1"},         32'(bus1.y),         32'(e_y1));
      chk({ph, ".q_sel1"},     32'(bus1.q_sel),     32'(m_q[a1]));
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_in(input logic g, input logic c, input int a, input logic dd);
      bus0.g_n   = g;
      bus0.clr_n = c;
      bus0.addr  = 3'(a);
      bus0.d     = dd;
   endtask

   task automatic cycle(input string ph);
      @(posedge clk);
      model_edge();
      #1;
      check_all(ph);
   endtask

   task automatic cycles(input int n, input string ph);
      for (int i = 0; i < n; i++) cycle(ph);
   endtask

   // Reset asserted between clock edges; outputs must clear without an edge.
   task automatic do_reset(input string ph);
      @(negedge clk);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_all(ph);
      chk({ph, ".q_zero"},    32'(bus0.q),         32'h0);
      chk({ph, ".addr_zero"}, 32'(bus0.scan_addr), 32'h0);
      chk({ph, ".wrap_zero"}, 32'(bus0.scan_wrap), 32'h0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      reset        = 1'b1;
      bus0.scan_en = 1'b0;
      set_in(1'b1, 1'b1, 0, 1'b0);
      model_reset();
      #1;
      check_all("por");
      @(negedge clk);
      reset = 1'b0;

      // Latch mode: build 8'hA5, then hold in memory mode.
      set_in(1'b0, 1'b1, 0, 1'b1); cycle("t1_w0");
      set_in(1'b0, 1'b1, 2, 1'b1); cycle("t1_w2");
      set_in(1'b0, 1'b1, 5, 1'b1); cycle("t1_w5");
      set_in(1'b0, 1'b1, 7, 1'b1); cycle("t1_w7");
      chk("t1_a5", 32'(bus0.q), 32'h0000_00A5);
      set_in(1'b1, 1'b1, 3, 1'b1); cycles(5, "t1_hold");
      chk("t1_hold_a5", 32'(bus0.q), 32'h0000_00A5);

      // Demux mode.
      set_in(1'b0, 1'b0, 3, 1'b1); cycle("t2_d1");
      chk("t2_08", 32'(bus0.q), 32'h0000_0008);
      set_in(1'b0, 1'b0, 3, 1'b0); cycle("t2_d0");
      chk("t2_00", 32'(bus0.q), 32'h0000_0000);

      // Clear mode from all ones.
      for (int a = 0; a < 8; a++) begin
         set_in(1'b0, 1'b1, a, 1'b1);
         cycle("t3_fill");
      end
      chk("t3_ff", 32'(bus0.q), 32'h0000_00FF);
      set_in(1'b1, 1'b0, 0, 1'b1); cycle("t3_clr");
      chk("t3_clr0", 32'(bus0.q), 32'h0000_0000);
      set_in(1'b1, 1'b1, 0, 1'b1); cycles(2, "t3_hold");

      // Free-running scan from reset, past one full wrap.
      do_reset("t4_rst");
      bus0.scan_en = 1'b1;
      cycles(31, "t4_scan");
      chk("t4_pre_wrap", 32'(bus0.scan_wrap), 32'h0);
      cycle("t4_wrap");
      chk("t4_wrap32", 32'(bus0.scan_wrap), 32'h1);
      cycles(6, "t4_post");

      // Mid-step disable at scan_addr 3.
      do_reset("t5_rst");
      bus0.scan_en = 1'b1;
      cycles(14, "t5_run");
      set_in(1'b0, 1'b1, 3, 1'b1);
      bus0.scan_en = 1'b0;
      cycles(3, "t5_off");
      chk("t5_hold3", 32'(bus0.scan_addr), 32'h3);
      set_in(1'b1, 1'b1, 0, 1'b0);
      bus0.scan_en = 1'b1;
      cycles(3, "t5_on");
      chk("t5_still3", 32'(bus0.scan_addr), 32'h3);
      cycle("t5_step");
      chk("t5_to4", 32'(bus0.scan_addr), 32'h4);

      // Randomized mix of all modes and scan enable.
      for (int i = 0; i < 300; i++) begin
         set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
                int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         bus0.scan_en = 1'($urandom_range(0, 9) != 0);
         cycle("rnd");
      end

      // Reset mid-operation with q=A5 and scan_addr=5.
      do_reset("t6_pre");
      bus0.scan_en = 1'b1;
      set_in(1'b0, 1'b1, 0, 1'b1); cycle("t6_w0");
      set_in(1'b0, 1'b1, 2, 1'b1); cycle("t6_w2");
      set_in(1'b0, 1'b1, 5, 1'b1); cycle("t6_w5");
      set_in(1'b0, 1'b1, 7, 1'b1); cycle("t6_w7");
      set_in(1'b1, 1'b1, 0, 1'b0);
      cycles(16, "t6_run");
      chk("t6_q_a5",  32'(bus0.q),         32'h0000_00A5);
      chk("t6_addr5", 32'(bus0.scan_addr), 32'h5);
      do_reset("t6_rst");
      cycles(2, "t6_after");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
